// File: rtl/palette_ram.sv
// Writable colour palette: index -> RGB lookup through a two-stage pipeline with
// per-read brightness fade, runtime writes over valid/ready, and a clear-to-black init.
module palette_ram #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [2:0]       fade_shift,
    output logic             rd_valid,
    output logic [CH_W-1:0]  red,
    output logic [CH_W-1:0]  green,
    output logic [CH_W-1:0]  blue,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [CH_W-1:0]  wr_red,
    input  logic [CH_W-1:0]  wr_green,
    input  logic [CH_W-1:0]  wr_blue,
    output logic             init_done
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int PIX_W   = 3 * CH_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] cnt_r;
    logic [PIX_W-1:0] table_r [ENTRIES];
    logic             valid1_r;
    logic [PIX_W-1:0] pix1_r;
    logic [2:0]       shift1_r;
    logic             wr_fire_s;

    assign wr_fire_s = wr_valid && wr_ready;

    // Logical right shift fade; shifting by the channel width or more blanks the channel.
    function automatic logic [CH_W-1:0] fade(input logic [CH_W-1:0] ch, input logic [2:0] sh);
        if (int'(sh) >= CH_W) begin
            fade = '0;
        end else begin
            fade = ch >> sh;
        end
    endfunction

    // Init/run sequencer: walks every entry once after reset, then opens the write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= INIT;
            cnt_r     <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    cnt_r <= cnt_r + IDX_W'(1);
                    if (cnt_r == LAST_IDX) begin
                        state_r   <= RUN;
                        init_done <= 1'b1;
                        wr_ready  <= 1'b1;
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                    wr_ready  <= 1'b1;
                end
                default: begin
                    state_r   <= INIT;
                    cnt_r     <= '0;
                    init_done <= 1'b0;
                    wr_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Palette storage: cleared entry by entry during init, loaded by accepted writes afterwards.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state_r == INIT) begin
                table_r[cnt_r] <= '0;
            end else if (wr_fire_s) begin
                table_r[wr_index] <= {wr_red, wr_green, wr_blue};
            end
        end
    end

    // Stage 1: fetch the entry (pre-write value on a same-cycle collision) and capture its fade.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid1_r <= 1'b0;
            pix1_r   <= '0;
            shift1_r <= 3'd0;
        end else begin
            valid1_r <= rd_en && (state_r == RUN);
            if (rd_en) begin
                pix1_r   <= table_r[rd_index];
                shift1_r <= fade_shift;
            end
        end
    end

    // Stage 2: apply the fade and register the result; outputs stay black while idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            rd_valid <= valid1_r;
            if (valid1_r) begin
                red   <= fade(pix1_r[3*CH_W-1:2*CH_W], shift1_r);
                green <= fade(pix1_r[2*CH_W-1:CH_W], shift1_r);
                blue  <= fade(pix1_r[CH_W-1:0], shift1_r);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_ram.sv
// Self-checking bench for palette_ram: scenario tasks drive stimulus and push expected
// lookups into a scoreboard; a monitor pops and compares every result as it emerges.
module tb_palette_ram;

    logic       clk;
    logic       reset;
    logic       rd_en;
    logic [3:0] rd_index;
    logic [2:0] fade_shift;
    logic       rd_valid;
    logic [3:0] red, green, blue;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_index;
    logic [3:0] wr_red, wr_green, wr_blue;
    logic       init_done;

    typedef struct {
        logic [11:0] rgb;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    palette_ram #(.IDX_W(4), .CH_W(4)) dut (
        .Clk        (clk),
        .Reset      (reset),
        .rd_en      (rd_en),
        .rd_index   (rd_index),
        .fade_shift (fade_shift),
        .rd_valid   (rd_valid),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_index   (wr_index),
        .wr_red     (wr_red),
        .wr_green   (wr_green),
        .wr_blue    (wr_blue),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid result must match the oldest expectation two cycles after issue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rgb=%h at cycle %0d, required no result", {red, green, blue}, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({red, green, blue} !== e.rgb || cyc !== e.cyc + 2) begin
                        errors++;
                        $display("FAIL lookup: got rgb=%h at cycle %0d, required rgb=%h at cycle %0d", {red, green, blue}, cyc, e.rgb, e.cyc + 2);
                    end
                end
            end else begin
                checks++;
                if (rd_valid !== 1'b0 || {red, green, blue} !== 12'h000) begin
                    errors++;
                    $display("FAIL idle_blank: got rd_valid=%b rgb=%h, required 0 and 000", rd_valid, {red, green, blue});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [3:0] idx, input logic [2:0] sh, input logic [11:0] exp_rgb);
        @(negedge clk);
        rd_en      = 1'b1;
        rd_index   = idx;
        fade_shift = sh;
        sb.push_back('{exp_rgb, cyc});
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_en = 1'b0;
            if (sb.size() == 0) break;
        end
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [11:0] rgb);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        rd_en    = 1'b0;
        wr_valid = 1'b1;
        wr_index = idx;
        {wr_red, wr_green, wr_blue} = rgb;
        for (int i = 0; i < 40; i++) begin
            if (wr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_timeout: got wr_ready=%b after 40 cycles, required 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at the negedge where Reset has just been released; optionally raises a write mid-init.
    task automatic wait_init(input int wr_at);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wr_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL init_busy: cycle %0d of init got wr_ready=%b init_done=%b, required 0 0", i, wr_ready, init_done);
            end
            rd_en      = 1'b1;
            rd_index   = 4'($urandom_range(0, 15));
            fade_shift = 3'd0;
            if (i == wr_at) begin
                wr_valid = 1'b1;
                wr_index = 4'd9;
                {wr_red, wr_green, wr_blue} = 12'hABC;
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_end: got wr_ready=%b init_done=%b, required 1 1", wr_ready, init_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || {red, green, blue} !== 12'h000 || wr_ready !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got rd_valid=%b rgb=%h wr_ready=%b init_done=%b, required all 0",
                     rd_valid, {red, green, blue}, wr_ready, init_done);
        end
        mon_en = 1'b1;
        reset  = 1'b0;
        wait_init(-1);
    endtask

    task automatic test_init_clear();
        for (int i = 0; i < 16; i++) issue(4'(i), 3'd0, 12'h000);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL init_clear_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_write_fade();
        write_entry(4'd3, 12'hE65);
        issue(4'd3, 3'd0, 12'hE65);
        issue(4'd3, 3'd1, 12'h732);
        issue(4'd3, 3'd4, 12'h000);
        issue(4'd3, 3'd7, 12'h000);
        issue(4'd3, 3'd2, 12'h311);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL fade_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        write_entry(4'd5, 12'hD53);
        issue(4'd3, 3'd0, 12'hE65);
        issue(4'd5, 3'd0, 12'hD53);
        issue(4'd3, 3'd0, 12'hE65);
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_valid: got rd_valid=%b, required 1", rd_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_en = 1'b0;
            checks++;
            if (rd_valid !== (k < 2)) begin
                errors++;
                $display("FAIL b2b_valid_run: step %0d got rd_valid=%b, required %b", k, rd_valid, (k < 2));
            end
        end
        checks++;
        if (sb.size() != 0 || {red, green, blue} !== 12'h000) begin
            errors++;
            $display("FAIL b2b_tail: got %0d outstanding rgb=%h, required 0 and 000", sb.size(), {red, green, blue});
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_valid   = 1'b1;
        wr_index   = 4'd7;
        {wr_red, wr_green, wr_blue} = 12'hFFF;
        rd_en      = 1'b1;
        rd_index   = 4'd7;
        fade_shift = 3'd0;
        sb.push_back('{12'h000, cyc});
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_ready: got wr_ready=%b, required 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_index = 4'd7;
        sb.push_back('{12'hFFF, cyc});
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL collision_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        write_entry(4'd3, 12'hE65);
        issue(4'd3, 3'd0, 12'hE65);
        issue(4'd3, 3'd0, 12'hE65);
        @(negedge clk);
        rd_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || sb.size() != 1) begin
            errors++;
            $display("FAIL reset_flush: got rd_valid=%b outstanding=%0d, required 0 and 1", rd_valid, sb.size());
        end
        sb.delete();
        reset = 1'b0;
        wait_init(-1);
        issue(4'd3, 3'd0, 12'h000);
        issue(4'd7, 3'd0, 12'h000);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_init_write();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_init(5);
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL init_write_held: got wr_valid=%b, required 1", wr_valid);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        issue(4'd9, 3'd0, 12'hABC);
        issue(4'd9, 3'd3, 12'h111);
        issue(4'd2, 3'd0, 12'h000);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL init_write_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        rd_en      = 1'b0;
        rd_index   = 4'd0;
        fade_shift = 3'd0;
        wr_valid   = 1'b0;
        wr_index   = 4'd0;
        wr_red     = 4'd0;
        wr_green   = 4'd0;
        wr_blue    = 4'd0;
        test_reset();
        test_init_clear();
        test_write_fade();
        test_back_to_back();
        test_collision();
        test_reset_midflight();
        test_init_write();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
